// File: rtl/csr_unit.sv
// Machine-mode CSR file: combinational read, committed writes, ecall/mret trap state.
// Optional mcycle/minstret counters are built when CSR_COUNTER_EN is defined.
module csr_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit,
  input  logic            csr_r_en,
  input  logic            csr_w_en,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_w_data,
  input  logic            inst_sys_ecall,
  input  logic            inst_sys_mret,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] csr_r_data,
  output logic            csr_illegal
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
`ifdef CSR_COUNTER_EN
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
`endif
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CSR_COUNTER_EN
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
`endif

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] rd_val;
  logic            addr_impl;
  logic            wr_fire;
  logic            trap_fire;
  logic            ret_fire;

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  assign mstatus_rd = XLEN'({2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000});

  always_comb begin
    rd_val    = '0;
    addr_impl = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS:  rd_val = mstatus_rd;
      ADDR_MTVEC:    rd_val = mtvec_q;
      ADDR_MSCRATCH: rd_val = mscratch_q;
      ADDR_MEPC:     rd_val = mepc_q;
      ADDR_MCAUSE:   rd_val = mcause_q;
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE:   rd_val = mcycle_q;
      ADDR_MINSTRET: rd_val = minstret_q;
`endif
      default:       addr_impl = 1'b0;
    endcase
  end

  assign csr_r_data  = csr_r_en ? rd_val : '0;
  assign csr_illegal = (csr_r_en | csr_w_en) & ~addr_impl;

  assign wr_fire   = commit & csr_w_en;
  assign trap_fire = commit & inst_sys_ecall;
  assign ret_fire  = commit & inst_sys_mret & ~inst_sys_ecall;

  // Next-state: software write first, trap/return overrides on shared CSRs.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef CSR_COUNTER_EN
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(commit);
`endif
    if (wr_fire) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = csr_w_data[3];
          mpie_d = csr_w_data[7];
        end
        ADDR_MTVEC:    mtvec_d    = csr_w_data & ALIGN_MASK;
        ADDR_MSCRATCH: mscratch_d = csr_w_data;
        ADDR_MEPC:     mepc_d     = csr_w_data & ALIGN_MASK;
        ADDR_MCAUSE:   mcause_d   = csr_w_data;
`ifdef CSR_COUNTER_EN
        ADDR_MCYCLE:   mcycle_d   = csr_w_data;
        ADDR_MINSTRET: minstret_d = csr_w_data;
`endif
        default: ;
      endcase
    end
    if (trap_fire) begin
      mepc_d   = pc & ALIGN_MASK;
      mcause_d = CAUSE_ECALL;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (ret_fire) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
`ifdef CSR_COUNTER_EN
      mcycle_q   <= '0;
      minstret_q <= '0;
`endif
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
`ifdef CSR_COUNTER_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter: XLEN, 64, data width of every CSR and data port; only 64 is supported.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 commit  input  1  instruction in decode/execute retires this cycle; gates every architectural state update.
REQ-006 csr_r_en  input  1  CSR read request from control-signal decode.
REQ-007 csr_w_en  input  1  CSR write request from control-signal decode.
REQ-008 csr_addr  input  12  CSR address; mtvec (0x305) on ecall/ebreak, mepc (0x341) on mret.
REQ-009 csr_w_data  input  XLEN  new CSR value from ALU (csrrw/s/c already resolved).
REQ-010 inst_sys_ecall  input  1  current instruction is ecall.
REQ-011 inst_sys_mret  input  1  current instruction is mret.
REQ-012 pc  input  XLEN  PC of current instruction.
REQ-013 csr_r_data  output  XLEN  read data; also jump target for ecall/ebreak/mret.
REQ-014 csr_illegal  output  1  csr_r_en or csr_w_en asserted with an unimplemented csr_addr.

Function
REQ-015 Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342; with counters enabled, mcycle 0xB00 and minstret 0xB02.
REQ-016 Read is combinational, zero latency: csr_r_data = selected CSR when csr_r_en=1, else 0.
REQ-017 Same-cycle read+write returns the pre-write value; write is visible from the next cycle.
REQ-018 Unimplemented address: csr_r_data=0, csr_illegal=1, no state change.
REQ-019 Write: on rising edge with commit=1 and csr_w_en=1, the addressed CSR takes csr_w_data subject to field masks; commit=0 ignores all inputs.
REQ-020 Field masks: mtvec[1:0] read 0 (direct mode only); mepc[1:0] read 0; mstatus writable only MIE[3], MPIE[7]; MPP[12:11] hardwired 2'b11; all other mstatus bits read 0.
REQ-021 ecall: commit=1 and inst_sys_ecall=1 -> mepc<=pc&~3, mcause<=64'd11, MPIE<=MIE, MIE<=0, all in one edge.
REQ-022 mret: commit=1 and inst_sys_mret=1 -> MIE<=MPIE, MPIE<=1; mepc unchanged.
REQ-023 Priority: trap/mret update beats csr_w_en on mepc, mcause and mstatus in the same cycle; csr_w_en to other CSRs still applies.
REQ-024 inst_sys_ecall and inst_sys_mret both high: ecall behaviour only.
REQ-025 ebreak causes no CSR state change; mtvec is read through csr_addr.

Reset
REQ-026 rst=1 at a rising edge: mstatus=64'h0000_0000_0000_1800, mtvec=0, mscratch=0, mepc=0, mcause=0, mcycle=0, minstret=0; overrides commit and all writes.
REQ-027 Reset mid-sequence (e.g., during a trap cycle) discards the update; outputs reflect reset values the following cycle.

Configuration
REQ-028 Macro CSR_COUNTER_EN: when defined, mcycle increments by 1 every non-reset cycle and minstret increments by 1 on every commit=1 cycle; both wrap from 2^64-1 to 0.
REQ-029 With CSR_COUNTER_EN, a committed write to mcycle/minstret loads csr_w_data and suppresses that cycle's increment.
REQ-030 Without CSR_COUNTER_EN, 0xB00/0xB02 are unimplemented (REQ-018) and no counter flops exist.

Verification
REQ-031 Reset then read 0x300 -> csr_r_data=0x1800; read 0x305 -> 0; csr_illegal=0.
REQ-032 Write mtvec=0x8000_0003 with commit -> next-cycle read 0x305 returns 0x8000_0000; same-cycle read returned old 0.
REQ-033 Set MIE via mstatus=0x8, ecall at pc=0x8000_0104 -> mepc=0x8000_0104, mcause=11, mstatus=0x1880; then mret -> mstatus=0x1888.
REQ-034 csr_r_en=1, csr_addr=0x7C0 -> csr_r_data=0, csr_illegal=1; write to 0x7C0 changes no CSR.
REQ-035 CSR_COUNTER_EN: write mcycle=64'hFFFF_FFFF_FFFF_FFFE, run 3 cycles -> reads ...FFFF, then 0, then 1; minstret counts only commit=1 cycles.
REQ-036 commit=0 with csr_w_en=1 and inst_sys_ecall=1 -> no CSR changes; rst asserted during an ecall cycle -> all CSRs at reset values.
